// File: rtl/fsm_vector_sweeper_if.sv
// rtl/fsm_vector_sweeper_if.sv - configuration, sweep control and FSM drive/check signals of the vector sweeper
interface fsm_vector_sweeper_if;
   logic       cfg_we;
   logic [1:0] cfg_state;
   logic [1:0] cfg_in;
   logic [1:0] cfg_ns;
   logic       cfg_out_we;
   logic [3:0] cfg_out;
   logic       start;
   logic [3:0] dut_out;
   logic [1:0] in;
   logic [1:0] cs;
   logic [1:0] ns;
   logic [3:0] exp_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_cnt;
   logic       err_valid;
   logic [3:0] first_err_idx;

   modport master (
      output cfg_we, cfg_state, cfg_in, cfg_ns, cfg_out_we, cfg_out, start, dut_out,
      input  in, cs, ns, exp_out, busy, done, pass, err_cnt, err_valid, first_err_idx
   );

   modport slave (
      input  cfg_we, cfg_state, cfg_in, cfg_ns, cfg_out_we, cfg_out, start, dut_out,
      output in, cs, ns, exp_out, busy, done, pass, err_cnt, err_valid, first_err_idx
   );
endinterface

// File: rtl/fsm_vector_sweeper.sv
// rtl/fsm_vector_sweeper.sv - sweeps all 16 (state, input) vectors into a Moore FSM and checks its output
module fsm_vector_sweeper #(
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               reset,
   fsm_vector_sweeper_if.slave bus
);
   typedef enum logic [1:0] {IDLE, HOLD, CHECK, DONE} state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

   state_t     state;
   logic [1:0] ns_tab [0:15];
   logic [3:0] out_tab [0:3];
   logic [3:0] idx;
   logic [3:0] settle_cnt;
   logic [3:0] nxt_idx;

   logic [1:0] in_r;
   logic [1:0] cs_r;
   logic [1:0] ns_r;
   logic [3:0] exp_out_r;
   logic       busy_r;
   logic       done_r;
   logic [4:0] err_cnt_r;
   logic       err_valid_r;
   logic [3:0] first_err_idx_r;

   // Vector about to be driven: 0 on a fresh start, idx+1 when leaving CHECK.
   assign nxt_idx = (state == CHECK) ? idx + 4'd1 : 4'd0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state           <= IDLE;
         idx             <= '0;
         settle_cnt      <= '0;
         in_r            <= '0;
         cs_r            <= '0;
         ns_r            <= '0;
         exp_out_r       <= '0;
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         err_cnt_r       <= '0;
         err_valid_r     <= 1'b0;
         first_err_idx_r <= '0;
         for (int i = 0; i < 16; i++) ns_tab[i] <= '0;
         for (int i = 0; i < 4; i++) out_tab[i] <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.cfg_we) begin
                  ns_tab[{bus.cfg_state, bus.cfg_in}] <= bus.cfg_ns;
                  if (bus.cfg_out_we) out_tab[bus.cfg_state] <= bus.cfg_out;
               end else if (bus.start) begin
                  state           <= HOLD;
                  idx             <= nxt_idx;
                  settle_cnt      <= '0;
                  cs_r            <= nxt_idx[3:2];
                  in_r            <= nxt_idx[1:0];
                  ns_r            <= ns_tab[nxt_idx];
                  exp_out_r       <= out_tab[nxt_idx[3:2]];
                  busy_r          <= 1'b1;
                  done_r          <= 1'b0;
                  err_cnt_r       <= '0;
                  err_valid_r     <= 1'b0;
                  first_err_idx_r <= '0;
               end
            end
            HOLD: begin
               if (settle_cnt == SETTLE_LAST) state <= CHECK;
               else settle_cnt <= settle_cnt + 4'd1;
            end
            CHECK: begin
               if (bus.dut_out != exp_out_r) begin
                  err_cnt_r <= err_cnt_r + 5'd1;
                  if (!err_valid_r) begin
                     err_valid_r     <= 1'b1;
                     first_err_idx_r <= idx;
                  end
               end
               if (idx == 4'd15) begin
                  state  <= DONE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
               end else begin
                  state      <= HOLD;
                  idx        <= nxt_idx;
                  settle_cnt <= '0;
                  cs_r       <= nxt_idx[3:2];
                  in_r       <= nxt_idx[1:0];
                  ns_r       <= ns_tab[nxt_idx];
                  exp_out_r  <= out_tab[nxt_idx[3:2]];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in            = in_r;
   assign bus.cs            = cs_r;
   assign bus.ns            = ns_r;
   assign bus.exp_out       = exp_out_r;
   assign bus.busy          = busy_r;
   assign bus.done          = done_r;
   assign bus.pass          = done_r && (err_cnt_r == 5'd0);
   assign bus.err_cnt       = err_cnt_r;
   assign bus.err_valid     = err_valid_r;
   assign bus.first_err_idx = first_err_idx_r;
endmodule

// File: tb/tb_fsm_vector_sweeper.sv
// tb/tb_fsm_vector_sweeper.sv - self-checking bench for fsm_vector_sweeper
module tb_fsm_vector_sweeper;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   fsm_vector_sweeper_if bus1 ();
   fsm_vector_sweeper_if bus3 ();

   fsm_vector_sweeper #(.SETTLE(1)) u_s1 (.clk(clk), .reset(reset), .bus(bus1.slave));
   fsm_vector_sweeper #(.SETTLE(3)) u_s3 (.clk(clk), .reset(reset), .bus(bus3.slave));

   logic       sel = 1'b0;
   logic       t_cfg_we = 1'b0;
   logic       t_cfg_out_we = 1'b0;
   logic       t_start = 1'b0;
   logic [1:0] t_cfg_state = '0;
   logic [1:0] t_cfg_in = '0;
   logic [1:0] t_cfg_ns = '0;
   logic [3:0] t_cfg_out = '0;
   logic [3:0] resp [16];

   assign bus1.cfg_we     = !sel && t_cfg_we;
   assign bus3.cfg_we     = sel && t_cfg_we;
   assign bus1.start      = !sel && t_start;
   assign bus3.start      = sel && t_start;
   assign bus1.cfg_out_we = t_cfg_out_we;
   assign bus3.cfg_out_we = t_cfg_out_we;
   assign bus1.cfg_state  = t_cfg_state;
   assign bus3.cfg_state  = t_cfg_state;
   assign bus1.cfg_in     = t_cfg_in;
   assign bus3.cfg_in     = t_cfg_in;
   assign bus1.cfg_ns     = t_cfg_ns;
   assign bus3.cfg_ns     = t_cfg_ns;
   assign bus1.cfg_out    = t_cfg_out;
   assign bus3.cfg_out    = t_cfg_out;
   // Stand-in FSM: its output is looked up per driven (cs, in) vector.
   assign bus1.dut_out    = resp[{bus1.cs, bus1.in}];
   assign bus3.dut_out    = resp[{bus3.cs, bus3.in}];

   wire [1:0] v_in    = sel ? bus3.in : bus1.in;
   wire [1:0] v_cs    = sel ? bus3.cs : bus1.cs;
   wire [1:0] v_ns    = sel ? bus3.ns : bus1.ns;
   wire [3:0] v_exp   = sel ? bus3.exp_out : bus1.exp_out;
   wire       v_busy  = sel ? bus3.busy : bus1.busy;
   wire       v_done  = sel ? bus3.done : bus1.done;
   wire       v_pass  = sel ? bus3.pass : bus1.pass;
   wire [4:0] v_cnt   = sel ? bus3.err_cnt : bus1.err_cnt;
   wire       v_valid = sel ? bus3.err_valid : bus1.err_valid;
   wire [3:0] v_first = sel ? bus3.first_err_idx : bus1.first_err_idx;

   logic [1:0] m_ns [16];
   logic [3:0] m_out [4];
   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] nsv;
      logic [15:0] outs;
      logic [63:0] rsp;
      logic [4:0]  e_cnt;
      logic [3:0]  e_first;
      logic        e_valid;
   } vec_t;
   vec_t vt [4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] s, input logic [1:0] i, input logic [1:0] n,
                     input logic owe, input logic [3:0] o);
      t_cfg_we = 1'b1; t_cfg_state = s; t_cfg_in = i; t_cfg_ns = n;
      t_cfg_out_we = owe; t_cfg_out = o;
      step();
      t_cfg_we = 1'b0; t_cfg_out_we = 1'b0;
      m_ns[{s, i}] = n;
      if (owe) m_out[s] = o;
   endtask

   task automatic program_table();
      for (int k = 0; k < 16; k++) begin
         logic [3:0] kk;
         kk = 4'(k);
         wr(kk[3:2], kk[1:0], m_ns[k], kk[1:0] == 2'd0, m_out[k / 4]);
      end
   endtask

   function automatic int exp_errs();
      int n = 0;
      for (int k = 0; k < 16; k++) if (resp[k] != m_out[k / 4]) n++;
      return n;
   endfunction

   function automatic int exp_first();
      for (int k = 0; k < 16; k++) if (resp[k] != m_out[k / 4]) return k;
      return 0;
   endfunction

   task automatic sweep(input int settle, input int start_at, input int write_at);
      int e_cnt, e_first;
      e_cnt = exp_errs();
      e_first = exp_first();
      t_start = 1'b1;
      step();
      t_start = 1'b0;
      chk("clr_err_cnt", 32'(v_cnt), 0);
      chk("clr_err_valid", 32'(v_valid), 0);
      chk("clr_done", 32'(v_done), 0);
      for (int idx = 0; idx < 16; idx++) begin
         chk("busy", 32'(v_busy), 1);
         chk("cs", 32'(v_cs), idx / 4);
         chk("in", 32'(v_in), idx % 4);
         chk("ns", 32'(v_ns), 32'(m_ns[idx]));
         chk("exp_out", 32'(v_exp), 32'(m_out[idx / 4]));
         for (int c = 0; c <= settle; c++) begin
            if (c == 0 && idx == start_at) t_start = 1'b1;
            if (c == 0 && idx == write_at) begin
               t_cfg_we = 1'b1; t_cfg_state = 2'd3; t_cfg_in = 2'd3;
               t_cfg_ns = ~m_ns[15]; t_cfg_out_we = 1'b1; t_cfg_out = ~m_out[3];
            end
            step();
            t_start = 1'b0; t_cfg_we = 1'b0; t_cfg_out_we = 1'b0;
         end
      end
      chk("done", 32'(v_done), 1);
      chk("busy_end", 32'(v_busy), 0);
      chk("err_cnt", 32'(v_cnt), 32'(e_cnt));
      chk("err_valid", 32'(v_valid), 32'(e_cnt != 0));
      chk("first_err_idx", 32'(v_first), 32'(e_first));
      chk("pass", 32'(v_pass), 32'(e_cnt == 0));
      chk("hold_cs", 32'(v_cs), 3);
      chk("hold_in", 32'(v_in), 3);
   endtask

   task automatic load_vec(input int n);
      for (int k = 0; k < 16; k++) begin
         m_ns[k] = vt[n].nsv[2*k +: 2];
         resp[k] = vt[n].rsp[4*k +: 4];
      end
      for (int s = 0; s < 4; s++) m_out[s] = vt[n].outs[4*s +: 4];
   endtask

   initial begin
      for (int k = 0; k < 16; k++) begin resp[k] = '0; m_ns[k] = '0; end
      for (int s = 0; s < 4; s++) m_out[s] = '0;

      // {table, responses, expected count, first index, valid}
      for (int n = 0; n < 4; n++) begin
         vt[n].nsv = '0; vt[n].outs = '0; vt[n].rsp = '0;
         if (n > 0) begin
            vt[n].outs = 16'h8421;
            for (int k = 0; k < 16; k++) begin
               vt[n].nsv[2*k +: 2] = 2'((k / 4 + k % 4) % 4);
               vt[n].rsp[4*k +: 4] = vt[n].outs[4*(k/4) +: 4];
            end
         end
      end
      for (int k = 8; k < 12; k++) vt[2].rsp[4*k +: 4] = 4'hF;
      vt[3].rsp[4*3 +: 4] = 4'h0;
      vt[3].rsp[4*15 +: 4] = 4'h0;
      vt[0].e_cnt = 5'd0; vt[0].e_first = 4'd0; vt[0].e_valid = 1'b0;
      vt[1].e_cnt = 5'd0; vt[1].e_first = 4'd0; vt[1].e_valid = 1'b0;
      vt[2].e_cnt = 5'd4; vt[2].e_first = 4'd8; vt[2].e_valid = 1'b1;
      vt[3].e_cnt = 5'd2; vt[3].e_first = 4'd3; vt[3].e_valid = 1'b1;

      reset = 1'b0;
      step(); step();
      chk("rst_in", 32'(bus1.in), 0);
      chk("rst_cs", 32'(bus1.cs), 0);
      chk("rst_ns", 32'(bus1.ns), 0);
      chk("rst_exp", 32'(bus1.exp_out), 0);
      chk("rst_busy", 32'(bus1.busy), 0);
      chk("rst_done", 32'(bus1.done), 0);
      chk("rst_pass", 32'(bus1.pass), 0);
      chk("rst_cnt", 32'(bus1.err_cnt), 0);
      chk("rst_valid", 32'(bus1.err_valid), 0);
      chk("rst_first", 32'(bus1.first_err_idx), 0);
      chk("rst3_busy", 32'(bus3.busy), 0);
      chk("rst3_done", 32'(bus3.done), 0);
      reset = 1'b1;
      step();
      chk("idle_busy", 32'(bus1.busy), 0);

      for (int n = 0; n < 4; n++) begin
         load_vec(n);
         if (n > 0) program_table();
         sweep(1, -1, -1);
         chk("tab_err_cnt", 32'(v_cnt), 32'(vt[n].e_cnt));
         chk("tab_first", 32'(v_first), 32'(vt[n].e_first));
         chk("tab_valid", 32'(v_valid), 32'(vt[n].e_valid));
      end

      // Start and table write while busy must both be ignored.
      load_vec(1);
      sweep(1, 3, 4);
      sweep(1, -1, -1);

      // Reset in the middle of a sweep with errors accumulating.
      for (int k = 0; k < 16; k++) resp[k] = 4'hF;
      t_start = 1'b1; step(); t_start = 1'b0;
      repeat (10) step();
      chk("mid_cs", 32'(v_cs), 1);
      chk("mid_in", 32'(v_in), 1);
      chk("mid_cnt", 32'(v_cnt), 5);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("mrst_busy", 32'(v_busy), 0);
      chk("mrst_done", 32'(v_done), 0);
      chk("mrst_cnt", 32'(v_cnt), 0);
      chk("mrst_valid", 32'(v_valid), 0);
      chk("mrst_cs", 32'(v_cs), 0);
      chk("mrst_exp", 32'(v_exp), 0);
      for (int k = 0; k < 16; k++) begin m_ns[k] = '0; resp[k] = '0; end
      for (int s = 0; s < 4; s++) m_out[s] = '0;

      // Write and start together in IDLE: the write wins.
      t_start = 1'b1;
      wr(2'd0, 2'd0, 2'd3, 1'b0, 4'h0);
      t_start = 1'b0;
      chk("we_start_busy", 32'(v_busy), 0);
      step();
      chk("we_start_busy2", 32'(v_busy), 0);
      chk("we_start_done", 32'(v_done), 0);
      sweep(1, -1, -1);

      for (int r = 0; r < 4; r++) begin
         for (int k = 0; k < 16; k++) m_ns[k] = 2'($urandom_range(0, 3));
         for (int s = 0; s < 4; s++) m_out[s] = 4'($urandom_range(0, 15));
         program_table();
         for (int k = 0; k < 16; k++)
            resp[k] = ($urandom_range(0, 3) == 0) ? m_out[k / 4] ^ 4'($urandom_range(1, 15))
                                                   : m_out[k / 4];
         sweep(1, -1, -1);
      end

      sel = 1'b1;
      for (int k = 0; k < 16; k++) m_ns[k] = 2'($urandom_range(0, 3));
      for (int s = 0; s < 4; s++) m_out[s] = 4'($urandom_range(1, 14));
      program_table();
      for (int k = 0; k < 16; k++) resp[k] = (k / 4 == 2) ? 4'hF : m_out[k / 4];
      sweep(3, -1, -1);
      for (int k = 0; k < 16; k++) resp[k] = m_out[k / 4];
      sweep(3, -1, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
